// File: rtl/edge_region_stats.sv
// Per-frame edge statistics behind the Sobel stage: edge pixel count and bounding box.
// Results are published once per frame with a one-cycle strobe; video passes through with one cycle of delay.
module edge_region_stats #(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480,
  parameter int          CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 per_frame_vsync,
  input  logic                 per_frame_href,
  input  logic                 per_img_Bit,
  input  logic [CNT_WIDTH-1:0] Min_Pixels,
  output logic                 post_frame_vsync,
  output logic                 post_frame_href,
  output logic                 post_img_Bit,
  output logic                 stat_valid,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic [10:0]          box_xmin,
  output logic [10:0]          box_xmax,
  output logic [10:0]          box_ymin,
  output logic [10:0]          box_ymax,
  output logic                 box_empty,
  output logic                 obj_detected
);

  function automatic logic [10:0] sat_inc_coord(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic                 vsync_p1, href_p1, bit_p1;
  logic                 vs_idle, armed, hit;
  logic [10:0]          x_cnt, y_cnt;
  logic [10:0]          run_xmin, run_xmax, run_ymin, run_ymax;
  logic [CNT_WIDTH-1:0] run_count;
  logic                 frame_start, frame_end, line_end, pix_ok, edge_pix;

  // vs_idle blocks a false frame start when reset releases in the middle of a frame
  assign frame_start = per_frame_vsync & ~vsync_p1 & vs_idle;
  assign frame_end   = ~per_frame_vsync & vsync_p1;
  assign line_end    = ~per_frame_href & href_p1;
  assign pix_ok      = armed & per_frame_vsync & per_frame_href &
                       (x_cnt < IMG_HDISP) & (y_cnt < IMG_VDISP);
  assign edge_pix    = pix_ok & per_img_Bit;

  assign post_frame_vsync = vsync_p1;
  assign post_frame_href  = href_p1;
  assign post_img_Bit     = bit_p1;

  // Stage p0 -> p1: input registers, running statistics and published results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_p1     <= 1'b0;
      href_p1      <= 1'b0;
      bit_p1       <= 1'b0;
      vs_idle      <= 1'b0;
      armed        <= 1'b0;
      hit          <= 1'b0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      run_count    <= '0;
      run_xmin     <= '0;
      run_xmax     <= '0;
      run_ymin     <= '0;
      run_ymax     <= '0;
      stat_valid   <= 1'b0;
      edge_count   <= '0;
      box_xmin     <= '0;
      box_xmax     <= '0;
      box_ymin     <= '0;
      box_ymax     <= '0;
      box_empty    <= 1'b1;
      obj_detected <= 1'b0;
    end else begin
      vsync_p1   <= per_frame_vsync;
      href_p1    <= per_frame_href;
      bit_p1     <= per_img_Bit & per_frame_href;
      stat_valid <= frame_end & armed;
      if (!per_frame_vsync) vs_idle <= 1'b1;

      if (frame_start) begin
        armed     <= 1'b1;
        hit       <= 1'b0;
        x_cnt     <= '0;
        y_cnt     <= '0;
        run_count <= '0;
        run_xmin  <= 11'h7FF;
        run_ymin  <= 11'h7FF;
        run_xmax  <= '0;
        run_ymax  <= '0;
      end else begin
        if (frame_end) armed <= 1'b0;
        if (per_frame_vsync & per_frame_href) begin
          x_cnt <= sat_inc_coord(x_cnt);
        end else if (line_end) begin
          x_cnt <= '0;
          y_cnt <= sat_inc_coord(y_cnt);
        end
        if (edge_pix) begin
          run_count <= sat_inc_cnt(run_count);
          hit       <= 1'b1;
          if (x_cnt < run_xmin) run_xmin <= x_cnt;
          if (x_cnt > run_xmax) run_xmax <= x_cnt;
          if (y_cnt < run_ymin) run_ymin <= y_cnt;
          if (y_cnt > run_ymax) run_ymax <= y_cnt;
        end
      end

      if (frame_end & armed) begin
        edge_count   <= run_count;
        box_xmin     <= hit ? run_xmin : 11'd0;
        box_xmax     <= hit ? run_xmax : 11'd0;
        box_ymin     <= hit ? run_ymin : 11'd0;
        box_ymax     <= hit ? run_ymax : 11'd0;
        box_empty    <= ~hit;
        obj_detected <= hit & (run_count >= Min_Pixels);
      end
    end
  end

endmodule

// File: tb/tb_edge_region_stats.sv
// Directed bench for edge_region_stats on an 8x4 image.
module tb_edge_region_stats;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vs = 1'b0, hr = 1'b0, bt = 1'b0;
  logic [CW-1:0] min_px = '0;
  logic          post_frame_vsync, post_frame_href, post_img_Bit, stat_valid;
  logic [CW-1:0] edge_count;
  logic [10:0]   box_xmin, box_xmax, box_ymin, box_ymax;
  logic          box_empty, obj_detected;

  int tests = 0;
  int fails = 0;
  int sv_pulses = 0;
  logic emap [0:3][0:15];
  logic pv, ph, pb, pr;

  always #5 clk = ~clk;

  edge_region_stats #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_img_Bit(bt), .Min_Pixels(min_px),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_img_Bit(post_img_Bit), .stat_valid(stat_valid), .edge_count(edge_count),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
    .box_empty(box_empty), .obj_detected(obj_detected)
  );

  always @(negedge clk) if (stat_valid === 1'b1) sv_pulses++;

  // Pass-through: inputs seen at an edge must appear on the outputs right after it
  always @(posedge clk) begin
    pr = rst_n; pv = vs; ph = hr; pb = bt;
    #1;
    tests++;
    if (post_frame_vsync !== (pr & pv) || post_frame_href !== (pr & ph) ||
        post_img_Bit !== (pr & ph & pb)) begin
      fails++;
      $display("FAIL passthrough got v=%b h=%b b=%b want v=%b h=%b b=%b", post_frame_vsync,
               post_frame_href, post_img_Bit, pr & pv, pr & ph, pr & ph & pb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic drive(input logic v, input logic h, input logic b);
    vs = v; hr = h; bt = b;
    @(negedge clk);
  endtask

  task automatic clear_map();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 16; x++) emap[y][x] = 1'b0;
  endtask

  task automatic send_lines(input int hlen);
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < hlen; x++) drive(1'b1, 1'b1, emap[y][x]);
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic send_frame(input int hlen);
    drive(1'b1, 1'b0, 1'b0);
    send_lines(hlen);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (stat_valid !== 1'b0) begin
      fails++; $display("FAIL reset_stat_valid got %b want 0", stat_valid);
    end
    tests++;
    if ({edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs got cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 0,0..0,0..0,1,0",
               edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (stat_valid !== 1'b0 || box_empty !== 1'b1) begin
      fails++; $display("FAIL reset_release got sv=%b empty=%b want 0 1", stat_valid, box_empty);
    end
  endtask

  task automatic test_single_edge();
    int p0;
    min_px = 20'd1;
    clear_map();
    emap[2][3] = 1'b1;
    p0 = sv_pulses;
    send_frame(8);
    tests++;
    if (stat_valid !== 1'b1) begin
      fails++; $display("FAIL single_stat_valid got %b want 1", stat_valid);
    end
    tests++;
    if ({edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd1, 11'd3, 11'd3, 11'd2, 11'd2, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL single_stats got cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,3..3,2..2,0,1",
               edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (stat_valid !== 1'b0 || edge_count !== 20'd1 || box_xmin !== 11'd3) begin
      fails++;
      $display("FAIL single_hold got sv=%b cnt=%0d xmin=%0d want 0 1 3", stat_valid, edge_count, box_xmin);
    end
    tests++;
    if (sv_pulses - p0 !== 1) begin
      fails++; $display("FAIL single_pulses got %0d want 1", sv_pulses - p0);
    end
  endtask

  task automatic test_multi_edge();
    int p0;
    min_px = 20'd4;
    clear_map();
    emap[0][1] = 1'b1;
    emap[3][6] = 1'b1;
    emap[1][4] = 1'b1;
    p0 = sv_pulses;
    send_frame(8);
    tests++;
    if (stat_valid !== 1'b1) begin
      fails++; $display("FAIL multi_stat_valid got %b want 1", stat_valid);
    end
    tests++;
    if ({edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd3, 11'd1, 11'd6, 11'd0, 11'd3, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL multi_stats got cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 3,1..6,0..3,0,0",
               edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (sv_pulses - p0 !== 1) begin
      fails++; $display("FAIL multi_pulses got %0d want 1", sv_pulses - p0);
    end
  endtask

  task automatic test_reset_midframe();
    int p0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b0);
    tests++;
    if (edge_count !== 20'd0 || box_empty !== 1'b1 || box_xmax !== 11'd0 || stat_valid !== 1'b0) begin
      fails++;
      $display("FAIL midreset_clear got cnt=%0d empty=%b xmax=%0d sv=%b want 0 1 0 0",
               edge_count, box_empty, box_xmax, stat_valid);
    end
    rst_n = 1'b1;
    p0 = sv_pulses;
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (sv_pulses - p0 !== 0 || box_empty !== 1'b1) begin
      fails++;
      $display("FAIL midreset_discard got pulses=%0d empty=%b want 0 1", sv_pulses - p0, box_empty);
    end
    min_px = 20'd1;
    clear_map();
    emap[0][0] = 1'b1;
    send_frame(8);
    tests++;
    if (stat_valid !== 1'b1) begin
      fails++; $display("FAIL midreset_stat_valid got %b want 1", stat_valid);
    end
    tests++;
    if ({edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd1, 11'd0, 11'd0, 11'd0, 11'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL midreset_stats got cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,0..0,0..0,0,1",
               edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (sv_pulses - p0 !== 1) begin
      fails++; $display("FAIL midreset_pulses got %0d want 1", sv_pulses - p0);
    end
  endtask

  task automatic test_empty_frame();
    min_px = 20'd0;
    clear_map();
    send_frame(8);
    tests++;
    if (stat_valid !== 1'b1 ||
        {edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL empty_stats got sv=%b cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,0,0..0,0..0,1,0",
               stat_valid, edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_long_line();
    min_px = 20'd0;
    clear_map();
    emap[1][8] = 1'b1;
    emap[1][9] = 1'b1;
    send_frame(10);
    tests++;
    if (stat_valid !== 1'b1 ||
        {edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL long_line_stats got sv=%b cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,0,0..0,0..0,1,0",
               stat_valid, edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int p0;
    min_px = 20'd1;
    clear_map();
    emap[1][2] = 1'b1;
    p0 = sv_pulses;
    send_frame(8);
    tests++;
    if (stat_valid !== 1'b1 ||
        {edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd1, 11'd2, 11'd2, 11'd1, 11'd1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL b2b_first got sv=%b cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,1,2..2,1..1,0,1",
               stat_valid, edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b1, 1'b0, 1'b0);
    tests++;
    if (stat_valid !== 1'b0 || edge_count !== 20'd1 || box_empty !== 1'b0 || box_ymax !== 11'd1) begin
      fails++;
      $display("FAIL b2b_hold got sv=%b cnt=%0d empty=%b ymax=%0d want 0 1 0 1",
               stat_valid, edge_count, box_empty, box_ymax);
    end
    clear_map();
    send_lines(8);
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (stat_valid !== 1'b1 ||
        {edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected} !==
        {20'd0, 11'd0, 11'd0, 11'd0, 11'd0, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL b2b_second got sv=%b cnt=%0d x=%0d..%0d y=%0d..%0d empty=%b obj=%b want 1,0,0..0,0..0,1,0",
               stat_valid, edge_count, box_xmin, box_xmax, box_ymin, box_ymax, box_empty, obj_detected);
    end
    drive(1'b0, 1'b0, 1'b0);
    tests++;
    if (sv_pulses - p0 !== 2) begin
      fails++; $display("FAIL b2b_pulses got %0d want 2", sv_pulses - p0);
    end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_multi_edge();
    test_reset_midframe();
    test_empty_frame();
    test_long_line();
    test_back_to_back();
    drive(1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
